// File: rtl/fight_referee.sv
// Turn-based referee for the two-player fighting game: synchronises the turn strobe,
// resolves moves/attacks, and runs the best-of-N round/match state machine.
module fight_referee #(
  parameter int unsigned ARENA_CELLS   = 5,
  parameter int unsigned POS_W         = 3,
  parameter int unsigned HEALTH_MAX    = 3,
  parameter int unsigned HEALTH_W      = 2,
  parameter int unsigned DAMAGE        = 1,
  parameter int unsigned ROUNDS_TO_WIN = 2,
  parameter int unsigned ROUND_W       = 2,
  parameter int unsigned PAUSE_CYCLES  = 4
) (
  input  logic                clk,
  input  logic                resetGame,
  input  logic                actionEnable,
  input  logic [2:0]          action1,
  input  logic [2:0]          action2,
  output logic [POS_W-1:0]    pos1,
  output logic [POS_W-1:0]    pos2,
  output logic [HEALTH_W-1:0] health1,
  output logic [HEALTH_W-1:0] health2,
  output logic [ROUND_W-1:0]  rounds1,
  output logic [ROUND_W-1:0]  rounds2,
  output logic                turnDone,
  output logic                roundOver,
  output logic                matchOver,
  output logic                firstWin,
  output logic                secondWin
);
  localparam logic [1:0] ST_PLAY       = 2'd0;
  localparam logic [1:0] ST_ROUND_OVER = 2'd1;
  localparam logic [1:0] ST_MATCH_OVER = 2'd2;

  localparam logic [2:0] ACT_LEFT   = 3'b001;
  localparam logic [2:0] ACT_RIGHT  = 3'b010;
  localparam logic [2:0] ACT_ATTACK = 3'b011;
  localparam logic [2:0] ACT_DEFEND = 3'b100;

  localparam int unsigned POS_LAST_I   = ARENA_CELLS - 1;
  localparam int unsigned PAUSE_LAST_I = PAUSE_CYCLES - 1;
  localparam logic [POS_W:0]      CELLS_X    = ARENA_CELLS[POS_W:0];
  localparam logic [POS_W-1:0]    POS_LAST   = POS_LAST_I[POS_W-1:0];
  localparam logic [HEALTH_W-1:0] HMAX       = HEALTH_MAX[HEALTH_W-1:0];
  localparam logic [HEALTH_W-1:0] DMG        = DAMAGE[HEALTH_W-1:0];
  localparam logic [ROUND_W-1:0]  RWIN       = ROUNDS_TO_WIN[ROUND_W-1:0];
  localparam logic [15:0]         PAUSE_LAST = PAUSE_LAST_I[15:0];

  logic [2:0]          sync_q;
  logic [1:0]          state_q, state_d;
  logic [POS_W-1:0]    pos1_q, pos1_d, pos2_q, pos2_d;
  logic [HEALTH_W-1:0] health1_q, health1_d, health2_q, health2_d;
  logic [ROUND_W-1:0]  rounds1_q, rounds1_d, rounds2_q, rounds2_d;
  logic [15:0]         pause_q, pause_d;
  logic                turn_done_q, turn_done_d;
  logic                win1_q, win1_d, win2_q, win2_d;

  logic                fire;
  logic [POS_W:0]      p1x, p2x, tgt1, tgt2;
  logic                mv1, mv2, blk1, blk2, adj, hit1, hit2;
  logic [POS_W-1:0]    p1n, p2n;
  logic [HEALTH_W-1:0] h1n, h2n;
  logic [ROUND_W-1:0]  r1inc, r2inc;

  assign fire = sync_q[1] & ~sync_q[2];

  // One extra position bit lets a left move from cell 0 wrap to a value outside the arena.
  assign p1x  = {1'b0, pos1_q};
  assign p2x  = {1'b0, pos2_q};
  assign tgt1 = (action1 == ACT_LEFT) ? p1x - 1'b1 : p1x + 1'b1;
  assign tgt2 = (action2 == ACT_LEFT) ? p2x - 1'b1 : p2x + 1'b1;
  assign mv1  = (action1 == ACT_LEFT) || (action1 == ACT_RIGHT);
  assign mv2  = (action2 == ACT_LEFT) || (action2 == ACT_RIGHT);
  assign blk1 = (tgt1 >= CELLS_X) || (tgt1 == p2x) || (mv2 && (tgt1 == tgt2));
  assign blk2 = (tgt2 >= CELLS_X) || (tgt2 == p1x) || (mv1 && (tgt2 == tgt1));
  assign p1n  = (mv1 && !blk1) ? tgt1[POS_W-1:0] : pos1_q;
  assign p2n  = (mv2 && !blk2) ? tgt2[POS_W-1:0] : pos2_q;

  assign adj  = (p1x + 1'b1 == p2x) || (p2x + 1'b1 == p1x);
  assign hit1 = (action1 == ACT_ATTACK) && adj && (action2 != ACT_DEFEND);
  assign hit2 = (action2 == ACT_ATTACK) && adj && (action1 != ACT_DEFEND);
  assign h2n  = hit1 ? ((health2_q >= DMG) ? health2_q - DMG : '0) : health2_q;
  assign h1n  = hit2 ? ((health1_q >= DMG) ? health1_q - DMG : '0) : health1_q;

  assign r1inc = (rounds1_q < RWIN) ? rounds1_q + 1'b1 : rounds1_q;
  assign r2inc = (rounds2_q < RWIN) ? rounds2_q + 1'b1 : rounds2_q;

  always_comb begin
    state_d     = state_q;
    pos1_d      = pos1_q;
    pos2_d      = pos2_q;
    health1_d   = health1_q;
    health2_d   = health2_q;
    rounds1_d   = rounds1_q;
    rounds2_d   = rounds2_q;
    pause_d     = pause_q;
    turn_done_d = 1'b0;
    win1_d      = win1_q;
    win2_d      = win2_q;
    case (state_q)
      ST_PLAY: begin
        if (fire) begin
          turn_done_d = 1'b1;
          pos1_d      = p1n;
          pos2_d      = p2n;
          health1_d   = h1n;
          health2_d   = h2n;
          if (h1n == '0 && h2n == '0) begin
            state_d = ST_ROUND_OVER;
            pause_d = '0;
          end else if (h2n == '0) begin
            rounds1_d = r1inc;
            pause_d   = '0;
            if (r1inc == RWIN) begin
              state_d = ST_MATCH_OVER;
              win1_d  = 1'b1;
            end else begin
              state_d = ST_ROUND_OVER;
            end
          end else if (h1n == '0) begin
            rounds2_d = r2inc;
            pause_d   = '0;
            if (r2inc == RWIN) begin
              state_d = ST_MATCH_OVER;
              win2_d  = 1'b1;
            end else begin
              state_d = ST_ROUND_OVER;
            end
          end
        end
      end
      ST_ROUND_OVER: begin
        if (pause_q == PAUSE_LAST) begin
          state_d   = ST_PLAY;
          pause_d   = '0;
          pos1_d    = '0;
          pos2_d    = POS_LAST;
          health1_d = HMAX;
          health2_d = HMAX;
        end else begin
          pause_d = pause_q + 16'd1;
        end
      end
      ST_MATCH_OVER: ;
      default: state_d = ST_PLAY;
    endcase
  end

  always_ff @(posedge clk or negedge resetGame) begin
    if (!resetGame) begin
      sync_q      <= '0;
      state_q     <= ST_PLAY;
      pos1_q      <= '0;
      pos2_q      <= POS_LAST;
      health1_q   <= HMAX;
      health2_q   <= HMAX;
      rounds1_q   <= '0;
      rounds2_q   <= '0;
      pause_q     <= '0;
      turn_done_q <= 1'b0;
      win1_q      <= 1'b0;
      win2_q      <= 1'b0;
    end else begin
      sync_q      <= {sync_q[1:0], actionEnable};
      state_q     <= state_d;
      pos1_q      <= pos1_d;
      pos2_q      <= pos2_d;
      health1_q   <= health1_d;
      health2_q   <= health2_d;
      rounds1_q   <= rounds1_d;
      rounds2_q   <= rounds2_d;
      pause_q     <= pause_d;
      turn_done_q <= turn_done_d;
      win1_q      <= win1_d;
      win2_q      <= win2_d;
    end
  end

  assign pos1      = pos1_q;
  assign pos2      = pos2_q;
  assign health1   = health1_q;
  assign health2   = health2_q;
  assign rounds1   = rounds1_q;
  assign rounds2   = rounds2_q;
  assign turnDone  = turn_done_q;
  assign roundOver = (state_q == ST_ROUND_OVER);
  assign matchOver = (state_q == ST_MATCH_OVER);
  assign firstWin  = win1_q;
  assign secondWin = win2_q;
endmodule
